counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit synchronous counter (clk/reset/enable/q). Accepts a run
//  command (target count, hold length) over a valid/ready handshake. Clears the
//  counter, then enables it for an exact number of cycles, honouring pause and abort.
//  Checks the final count, holds, then pulses done. Sits between the command source
//  and the counter instance.
// PARAMETERS
//  W       4  counter width; cnt_q/cmd_target width
//  HOLD_W  4  width of cmd_hold (post-run idle cycles)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-low reset (0 = reset asserted)
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       controller can accept a command (= state IDLE)
//  cmd_target  in   W       final count; 0 means a full 2^W-cycle wrap run
//  cmd_hold    in   HOLD_W  cycles to stay in HOLD after the check
//  pause       in   1       gates cnt_en while in RUN; no other effect
//  abort       in   1       cancels an in-flight command
//  cnt_q       in   W       counter output q
//  cnt_clr     out  1       drives counter reset (active-high synchronous clear)
//  cnt_en      out  1       drives counter enable
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle completion pulse
//  err         out  1       sticky count-mismatch flag
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, remaining=0, hold_cnt=0. cnt_clr=0, cnt_en=0,
//   busy=0, done=0, err=0, cmd_ready=1.
//  States: IDLE, CLEAR, RUN, CHECK, HOLD, DONE.
//  IDLE: cmd_ready=1. On cmd_valid at an edge, latch target/hold, clear err -> CLEAR.
//  CLEAR: exactly 1 cycle, cnt_clr=1, cnt_en=0. Load remaining = N, where
//   N = (target==0) ? 2^W : target; remaining is W+1 bits wide. -> RUN.
//  RUN: cnt_en = !pause (combinational, same-cycle effect). Each cycle with cnt_en=1
//   decrements remaining. At the edge where remaining goes 1->0 -> CHECK.
//   Exactly N enabled cycles per command, regardless of pause pattern.
//  CHECK: 1 cycle, cnt_en=0. If cnt_q != target[W-1:0], err<=1 (visible next cycle).
//   -> HOLD if hold!=0 (hold_cnt=hold), else DONE.
//  HOLD: cnt_en=0 for exactly hold cycles; pause ignored. -> DONE.
//  DONE: done=1 for 1 cycle -> IDLE.
//  Outputs are Moore-decoded from state except cnt_en (state==RUN && !pause).
//  Latency, no pause: accept edge = cycle 0. CLEAR in cycle 1, RUN in cycles 2..N+1,
//   CHECK in N+2, done=1 in cycle N+H+3.
//  Pause adds one cycle of latency per paused RUN cycle.
//  abort: in any non-IDLE state, at the edge -> IDLE. No done pulse; err unchanged.
//   cnt_en/cnt_clr are 0 from the next cycle. abort outranks all other transitions.
//   In IDLE abort is ignored; abort+cmd_valid in IDLE accepts the command.
//  cmd_valid outside IDLE is ignored (not queued).
//  err holds until the next accepted command.
//  Wrap: target=0 counts 0..15 and back to 0; CHECK expects 0.
//  Async reset mid-operation forces the reset values immediately, counter clear not
//   issued; the next command's CLEAR re-zeroes the counter.
// TESTING
//  1 target=5, hold=0, no pause -> cnt_clr in cycle 1; cnt_en cycles 2-6; cnt_q=5 at
//    CHECK; done in cycle 8; err=0.
//  2 target=0, hold=2 -> 16 cnt_en cycles, q wraps 15->0; done in cycle 21; err=0.
//  3 target=6, hold=0, pause high 3 cycles mid-RUN -> exactly 6 cnt_en cycles; done
//    in cycle 12.
//  4 counter model stuck at 3, target=4 -> err=1 after CHECK; done still pulses;
//    err=0 after the next accept.
//  5 abort after 2 enabled RUN cycles -> cnt_en=0, busy=0, cmd_ready=1 next cycle;
//    no done; following target=2 command completes normally.
//  6 reset=0 mid-RUN -> all outputs at reset values immediately, cmd_ready=1; next
//    command issues CLEAR and a full run.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Run sequencer for a W-bit counter: clear, enable for exactly N cycles,
// verify the final count, hold, then pulse done.
module counter_seq_ctrl #(
    parameter int W      = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_target,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              pause,
    input  logic              abort,
    input  logic [W-1:0]      cnt_q,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CHECK,
        HOLD,
        DONE
    } state_t;

    // A target of zero means one full wrap, i.e. 2^W enabled cycles.
    localparam logic [W:0] FULL_RUN = {1'b1, {W{1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic [W-1:0]      target_q;
    logic [HOLD_W-1:0] hold_q;
    logic [W:0]        remaining;
    logic [HOLD_W-1:0] hold_cnt;
    logic              kill;

    assign kill = abort && (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_en = !pause;
                if (!pause && remaining == (W+1)'(1)) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = (hold_q != '0) ? HOLD : DONE;
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q  <= '0;
            hold_q    <= '0;
            remaining <= '0;
            hold_cnt  <= '0;
            err       <= 1'b0;
        end else if (!kill) begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        hold_q   <= cmd_hold;
                        err      <= 1'b0;
                    end
                end
                CLEAR: begin
                    remaining <= (target_q == '0) ? FULL_RUN
                                                  : {1'b0, target_q};
                end
                RUN: begin
                    if (cnt_en) begin
                        remaining <= remaining - (W+1)'(1);
                    end
                end
                CHECK: begin
                    if (cnt_q != target_q) begin
                        err <= 1'b1;
                    end
                    hold_cnt <= hold_q;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 4-bit counter
// (optionally stuck at 3) closing the loop.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_target;
    logic [3:0] cmd_hold;
    logic       pause;
    logic       abort;
    logic [3:0] cnt_q;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] q_m = 4'd9;
    logic       stuck = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Counter model: no reset of its own, only the synchronous clear.
    always @(posedge clk) begin
        if (cnt_clr) begin
            q_m <= 4'd0;
        end else if (cnt_en) begin
            q_m <= q_m + 4'd1;
        end
    end

    assign cnt_q = stuck ? 4'd3 : q_m;

    counter_seq_ctrl #(.W(4), .HOLD_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_hold   (cmd_hold),
        .pause      (pause),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [3:0] target;
        logic [3:0] hold;
        int         p_from;
        int         p_len;
        int         exp_en;
        int         exp_done;
        int         exp_q;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issues one command and follows it to its done pulse. Cycle 0 ends
    // at the accept edge; outputs are sampled 1ns after each falling edge.
    task automatic run_cmd(
        input  logic [3:0] tgt,
        input  logic [3:0] hld,
        input  int         p_from,
        input  int         p_len,
        output int         en_cnt,
        output int         done_cyc,
        output int         q_done,
        output int         clr_cyc
    );
        int cyc;
        en_cnt   = 0;
        done_cyc = -1;
        q_done   = -1;
        clr_cyc  = -1;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_hold   = hld;
        #1;
        chk("ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            pause = (cyc >= p_from) && (cyc < p_from + p_len);
            #1;
            if (cnt_en) en_cnt++;
            if (cnt_clr) clr_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                q_done   = int'(cnt_q);
                break;
            end
        end
        pause = 1'b0;
        if (done_cyc < 0) begin
            chk("done_timeout", 0, 1);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int en_cnt;
        int done_cyc;
        int q_done;
        int clr_cyc;
        int seen;

        vecs[0] = '{4'd5,  4'd0, 0, 0, 5,  8,  5};
        vecs[1] = '{4'd0,  4'd2, 0, 0, 16, 21, 0};
        vecs[2] = '{4'd6,  4'd0, 4, 3, 6,  12, 6};
        vecs[3] = '{4'd1,  4'd0, 0, 0, 1,  4,  1};
        vecs[4] = '{4'd15, 4'd15, 0, 0, 15, 33, 15};
        vecs[5] = '{4'd3,  4'd1, 2, 1, 3,  8,  3};
        vecs[6] = '{4'd2,  4'd3, 5, 3, 2,  8,  2};

        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = 4'd0;
        cmd_hold   = 4'd0;
        pause      = 1'b0;
        abort      = 1'b0;
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].target, vecs[i].hold, vecs[i].p_from,
                    vecs[i].p_len, en_cnt, done_cyc, q_done, clr_cyc);
            chk($sformatf("v%0d_clr_cycle", i), clr_cyc, 1);
            chk($sformatf("v%0d_en_cycles", i), en_cnt, vecs[i].exp_en);
            chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("v%0d_q_at_end", i), q_done, vecs[i].exp_q);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_err", i), int'(err), 0);
            chk($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
            chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
        end

        // Stuck counter: mismatch flagged, done still pulses.
        stuck = 1'b1;
        run_cmd(4'd4, 4'd0, 0, 0, en_cnt, done_cyc, q_done, clr_cyc);
        chk("stuck_done_cycle", done_cyc, 7);
        chk("stuck_err_in_done", int'(err), 1);
        @(negedge clk);
        #1;
        chk("stuck_err_sticky", int'(err), 1);
        stuck = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = 4'd2;
        cmd_hold   = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("stuck_err_cleared", int'(err), 0);
        chk("stuck_next_clr", int'(cnt_clr), 1);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("stuck_next_done", seen, 1);
        chk("stuck_next_q", int'(cnt_q), 2);
        chk("stuck_next_err", int'(err), 0);

        // Abort after two enabled RUN cycles.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 4'd8;
        cmd_hold   = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_run1_en", int'(cnt_en), 1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_run2_en", int'(cnt_en), 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_cnt_en", int'(cnt_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_q", int'(cnt_q), 2);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || cnt_en || cnt_clr) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        run_cmd(4'd2, 4'd0, 0, 0, en_cnt, done_cyc, q_done, clr_cyc);
        chk("post_abort_en", en_cnt, 2);
        chk("post_abort_done", done_cyc, 5);
        chk("post_abort_q", q_done, 2);

        // Async reset mid-RUN.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 4'd10;
        cmd_hold   = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid_en_before", int'(cnt_en), 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_cnt_en", int'(cnt_en), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(cmd_ready), 1);
        chk("rst_mid_clr", int'(cnt_clr), 0);
        chk("rst_mid_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        run_cmd(4'd3, 4'd0, 0, 0, en_cnt, done_cyc, q_done, clr_cyc);
        chk("post_rst_clr", clr_cyc, 1);
        chk("post_rst_en", en_cnt, 3);
        chk("post_rst_done", done_cyc, 6);
        chk("post_rst_q", q_done, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

endmodule
